// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // Divisors of 0 or 1 cannot form a period with both a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with registered divided waveform and end-of-period tick.
// Outputs are computed from the next counter value so that div_out and tick
// line up with the cycle in which the counter holds that value.
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             boundary,
    output logic             div_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] last_cnt;

    assign high_cnt = div - (div >> 1);
    assign last_cnt = div - 1'b1;
    assign boundary = active_q && (cnt_q == last_cnt);

    // Next counter value and the waveform/tick that value implies.
    always_comb begin
        cnt_d     = '0;
        active_d  = en;
        if (en && active_q && !boundary) begin
            cnt_d = cnt_q + 1'b1;
        end
        div_out_d = en && (cnt_d < high_cnt);
        tick_d    = en && (cnt_d == last_cnt);
    end

    // Counter and output registers; reset kills any period in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            active_q  <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_out = div_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time programmable clock divider: run/drain/stop FSM plus a one-deep
// divisor holding register that is only applied at a period boundary.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             boundary;
    logic             en;
    logic             handshake;
    logic             apply_pend;

    // Next state, divisor hand-over and capture of a newly offered divisor.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cur_div_d    = cur_div_q;

        case (state_q)
            STOP:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = DRAIN;
            DRAIN: begin
                if (run) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = STOP;
                end
            end
            default: state_d = STOP;
        endcase

        en = (state_d != STOP);

        handshake  = cfg_valid && !pend_valid_q;
        apply_pend = pend_valid_q && ((state_q == STOP) || boundary);

        if (apply_pend) begin
            cur_div_d    = pend_q;
            pend_valid_d = 1'b0;
        end
        if (handshake) begin
            pend_d       = CNT_W'(clamp_div(32'(cfg_div)));
            pend_valid_d = 1'b1;
        end
    end

    // FSM and configuration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= STOP;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cur_div_q    <= CNT_W'(RESET_DIV);
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cur_div_q    <= cur_div_d;
        end
    end

    clkdiv_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en),
        .div     (cur_div_q),
        .boundary(boundary),
        .div_out (div_out),
        .tick    (tick)
    );

    assign cfg_ready = !pend_valid_q;
    assign busy      = pend_valid_q;
    assign cur_div   = cur_div_q;

endmodule
